uart_tx: RTL

Serial transmitter: the stage directly upstream of the UART receiver. It takes bytes through a valid/ready handshake and drives them onto the line as 8N1 frames: one start bit (0), eight data bits LSB first, one stop bit (1). A one-byte holding register lets the next byte queue while the current frame shifts, so back-to-back frames go out with no idle gap. In loopback, `serial_out` connects straight to the receiver's `serial_in`.

---
 rtl/uart_tx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-byte holding register.
// A byte is taken through valid/ready into the holding register, then moved
// into the shifter when the line is free. Loading straight from the end of a
// stop bit lets queued bytes go out back-to-back with no idle bit.
module uart_tx #(
    parameter int BASE_CLK     = 50_000_000,
    parameter int BAUDRATE     = 115_200,
    parameter int CLKS_PER_BIT = BASE_CLK / BAUDRATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       busy,
    output logic       done
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        hold_q;
    logic              hold_full_q, hold_full_d;
    logic              serial_q, serial_d;
    logic              accept;
    logic              bit_end;

    // A handshake can only happen while the holding register is empty, so it
    // never collides with a shifter load (which needs the register full).
    assign accept   = tx_valid && !hold_full_q;
    assign bit_end  = (baud_q == BAUD_LAST);

    assign tx_ready   = !hold_full_q;
    assign serial_out = serial_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == STOP) && bit_end;

    // Next-state, counters, shifter and holding-register flag.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;

        if (accept) begin
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (hold_full_q) begin
                        // Chain straight into the next start bit.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line is registered from the upcoming state, so it changes on
        // the same edge as the state and only on bit boundaries.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
    end

    // Control state: async active-low reset aborts any frame and drops the held byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            hold_full_q <= 1'b0;
            serial_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            hold_full_q <= hold_full_d;
            serial_q    <= serial_d;
        end
    end

    // Data registers: contents are only meaningful when qualified by control state.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (accept) begin
            hold_q <= tx_data;
        end
    end

endmodule
